// File: rtl/sp_mem_bidir_ctrl.sv
// sp_mem_bidir_ctrl: parametrised single-port RAM on a shared bidirectional bus
module sp_mem_bidir_ctrl #(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [DATA_W-1:0]   data_io,
  input  logic [ADDR_W-1:0]   address,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                ready,
  output logic                rd_valid,
  output logic                err
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] pipe [RD_LAT];
  logic              in_range, wr_acc, rd_acc, err_nxt;
  assign ready    = state == RUN;
  assign rd_valid = vld[RD_LAT-1];
  assign in_range = 32'(address) < DEPTH;
  assign wr_acc   = ready && wr_en && !rd_en && in_range && !rd_valid;
  assign rd_acc   = ready && rd_en && !wr_en;
  assign err_nxt  = ready && (wr_en ? (rd_en || rd_valid || !in_range) : (rd_en && !in_range));
  assign data_io  = rd_valid ? pipe[RD_LAT-1] : 'z;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      vld      <= '0;
      err      <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        if (CLEAR_ON_RESET == 0 || clr_addr == ADDR_W'(DEPTH-1)) state <= RUN;
      end
      vld <= RD_LAT'({vld, rd_acc});
      err <= err_nxt;
    end
  // out-of-range reads still take a pipeline slot and return zero
  always_ff @(posedge clk) begin
    pipe[0] <= in_range ? mem[address] : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  always_ff @(posedge clk)
    if (state == CLEAR && CLEAR_ON_RESET != 0) mem[clr_addr] <= '0;
    else if (wr_acc)
      for (int i = 0; i < DATA_W/8; i++)
        if (byte_en[i]) mem[address][8*i+:8] <= data_io[8*i+:8];
endmodule
